// File: rtl/wave_capture_if.sv
// Sample-stream and capture-RAM signals shared by wave_capture and its neighbours.
// The master side sources samples and display status; the slave side is the capture block.
interface wave_capture_if #(
    parameter int SAMPLE_W   = 16,
    parameter int DEPTH_LOG2 = 8
);
    // new_sample_ready is a one-cycle strobe qualifying new_sample_in with no backpressure;
    // write_enable is a one-cycle strobe qualifying write_address/write_sample, no ready.
    logic                  new_sample_ready;
    logic [SAMPLE_W-1:0]   new_sample_in;
    logic                  wave_display_idle;
    logic                  write_enable;
    logic [DEPTH_LOG2:0]   write_address;
    logic [7:0]            write_sample;
    logic                  read_index;

    modport master (
        output new_sample_ready, new_sample_in, wave_display_idle,
        input  write_enable, write_address, write_sample, read_index
    );

    modport slave (
        input  new_sample_ready, new_sample_in, wave_display_idle,
        output write_enable, write_address, write_sample, read_index
    );
endinterface

// File: rtl/wave_capture.sv
// Zero-crossing triggered capture of 2**DEPTH_LOG2 samples into the non-displayed RAM half.
// Define WAVE_CAPTURE_TIMEOUT_EN to add a free-run trigger after TIMEOUT_SAMPLES strobes.
module wave_capture #(
    parameter int SAMPLE_W        = 16,
    parameter int DEPTH_LOG2      = 8,
    parameter int TIMEOUT_SAMPLES = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    wave_capture_if.slave        bus,
    output logic [1:0]           dbg_state_o
);
    typedef enum logic [1:0] {
        ARMED  = 2'd0,
        ACTIVE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t                state_q;
    logic [DEPTH_LOG2-1:0] count_q;
    logic                  prev_neg_q;
    logic                  we_q;
    logic [DEPTH_LOG2:0]   addr_q;
    logic [7:0]            sample_q;
    logic                  ri_q;

    logic       strobe;
    logic       cur_neg;
    logic       crossing;
    logic       timeout_hit;
    logic [7:0] conv;
    logic       unused_lsbs;

    assign strobe      = bus.new_sample_ready;
    assign cur_neg     = bus.new_sample_in[SAMPLE_W-1];
    assign crossing    = prev_neg_q & ~cur_neg;
    assign conv        = {~bus.new_sample_in[SAMPLE_W-1], bus.new_sample_in[SAMPLE_W-2:SAMPLE_W-8]};
    assign unused_lsbs = ^bus.new_sample_in[SAMPLE_W-9:0];

`ifdef WAVE_CAPTURE_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_SAMPLES + 1);
    logic [TO_W-1:0] to_cnt_q;

    assign timeout_hit = (to_cnt_q == TO_W'(TIMEOUT_SAMPLES - 1));

    // Held at zero outside ARMED, so every entry into ARMED starts a fresh count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt_q <= '0;
        end else if (state_q != ARMED) begin
            to_cnt_q <= '0;
        end else if (strobe) begin
            to_cnt_q <= to_cnt_q + TO_W'(1);
        end
    end
`else
    logic unused_timeout;
    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT_SAMPLES != 0);
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ARMED;
            count_q    <= '0;
            prev_neg_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            sample_q   <= '0;
            ri_q       <= 1'b0;
        end else begin
            we_q <= 1'b0;
            if (strobe) begin
                prev_neg_q <= cur_neg;
            end
            case (state_q)
                ARMED: begin
                    if (strobe && (crossing || timeout_hit)) begin
                        we_q     <= 1'b1;
                        addr_q   <= {~ri_q, {DEPTH_LOG2{1'b0}}};
                        sample_q <= conv;
                        count_q  <= DEPTH_LOG2'(1);
                        state_q  <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (strobe) begin
                        we_q     <= 1'b1;
                        addr_q   <= {~ri_q, count_q};
                        sample_q <= conv;
                        count_q  <= count_q + DEPTH_LOG2'(1);
                        if (count_q == {DEPTH_LOG2{1'b1}}) begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Swap waits one edge past the last write so the two never coincide.
                    if (bus.wave_display_idle) begin
                        ri_q    <= ~ri_q;
                        state_q <= ARMED;
                    end
                end
                default: state_q <= ARMED;
            endcase
        end
    end

    assign bus.write_enable  = we_q;
    assign bus.write_address = addr_q;
    assign bus.write_sample  = sample_q;
    assign bus.read_index    = ri_q;
    assign dbg_state_o       = state_q;
endmodule
